// File: rtl/coarse_peak_finder_pkg.sv
// coarse_peak_finder_pkg: widths, FSM encodings and drain length for the peak finder.
// PEAK_SUM3_EN selects the 3-bin window score, which adds one drain cycle.
package coarse_peak_finder_pkg;
    localparam int NB_DEF = 5;
    localparam int CW_DEF = 10;
    localparam logic [1:0] PF_IDLE  = 2'd0;
    localparam logic [1:0] PF_READ  = 2'd1;
    localparam logic [1:0] PF_DRAIN = 2'd2;
    localparam logic [1:0] PF_DONE  = 2'd3;
`ifdef PEAK_SUM3_EN
    localparam int DRAIN_CYC = 2;
`else
    localparam int DRAIN_CYC = 1;
`endif
endpackage

// File: rtl/binWindowSum3.sv
// binWindowSum3: 3-tap sliding sum over the bin stream, scored at the centre bin (PEAK_SUM3_EN).
// Neighbours outside the histogram are zeroed via the first/last flags.
module binWindowSum3
    import coarse_peak_finder_pkg::*;
#(
    parameter int NB = NB_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          res,
    input  logic          in_valid,
    input  logic          in_first,
    input  logic          in_last,
    input  logic [CW-1:0] in_data,
    input  logic [NB-1:0] in_idx,
    output logic          out_valid,
    output logic [CW+1:0] out_score,
    output logic [NB-1:0] out_idx
);
    logic [CW-1:0] cur_q, prev_q;
    logic [NB-1:0] idx_q;
    logic          v_q, last_q;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            cur_q  <= '0;
            prev_q <= '0;
            idx_q  <= '0;
            v_q    <= 1'b0;
            last_q <= 1'b0;
        end else begin
            v_q <= in_valid;
            if (in_valid) begin
                prev_q <= in_first ? '0 : cur_q;
                cur_q  <= in_data;
                last_q <= in_last;
                idx_q  <= in_idx;
            end
        end
    end

    // the live input is the right neighbour of the registered centre bin
    assign out_score = (CW+2)'(prev_q) + (CW+2)'(cur_q) + (last_q ? '0 : (CW+2)'(in_data));
    assign out_valid = v_q;
    assign out_idx   = idx_q;
endmodule

// File: rtl/coarse_peak_finder.sv
// coarse_peak_finder: scans one coarse TDC histogram from RAM and reports the highest bin.
// PEAK_SUM3_EN scores each bin as the sum of itself and its two neighbours.
module coarse_peak_finder
    import coarse_peak_finder_pkg::*;
#(
    parameter int NB = NB_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          res,
    input  logic          start,
    input  logic [CW-1:0] minCount,
    output logic          rdEn,
    output logic [NB-1:0] rdAddr,
    input  logic [CW-1:0] rdData,
    output logic [NB-1:0] peakCH,
    output logic [CW+1:0] peakCount,
    output logic          peakValid,
    output logic          peakDone,
    output logic          busy
);
    localparam logic [NB-1:0] LAST = '1;

    logic [1:0]    state_q, state_d;
    logic [NB-1:0] addr_q, addr_d, idx_q, idx_d, ch_q, ch_d, didx_q, sc_idx, nidx;
    logic [CW-1:0] min_q, min_d;
    logic [CW+1:0] max_q, max_d, cnt_q, cnt_d, sc, nmax;
    logic          drn_q, drn_d, dvalid_q, valid_q, valid_d, done_q, sc_v, fin;

`ifdef PEAK_SUM3_EN
    binWindowSum3 #(.NB(NB), .CW(CW)) u_win (
        .clk      (clk),
        .res      (res),
        .in_valid (dvalid_q),
        .in_first (didx_q == '0),
        .in_last  (didx_q == LAST),
        .in_data  (rdData),
        .in_idx   (didx_q),
        .out_valid(sc_v),
        .out_score(sc),
        .out_idx  (sc_idx)
    );
`else
    assign sc     = {2'b00, rdData};
    assign sc_v   = dvalid_q;
    assign sc_idx = didx_q;
`endif

    // strict compare keeps the lowest index on ties
    assign nmax = (sc_v && sc > max_q) ? sc : max_q;
    assign nidx = (sc_v && sc > max_q) ? sc_idx : idx_q;
    assign fin  = state_q == PF_DRAIN && drn_q == 1'(DRAIN_CYC - 1);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        min_d   = min_q;
        max_d   = nmax;
        idx_d   = nidx;
        drn_d   = drn_q;
        case (state_q)
            PF_IDLE: if (start) begin
                state_d = PF_READ;
                addr_d  = '0;
                min_d   = minCount;
                max_d   = '0;
                idx_d   = '0;
            end
            PF_READ: if (addr_q == LAST) begin
                state_d = PF_DRAIN;
                drn_d   = 1'b0;
            end else addr_d = addr_q + 1'b1;
            PF_DRAIN: if (fin) state_d = PF_DONE; else drn_d = 1'b1;
            default: state_d = PF_IDLE;
        endcase
    end

    assign valid_d = fin ? nmax >= {2'b00, min_q} : valid_q;
    assign ch_d    = fin ? (valid_d ? nidx : '0) : ch_q;
    assign cnt_d   = fin ? nmax : cnt_q;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q  <= PF_IDLE;
            addr_q   <= '0;
            min_q    <= '0;
            max_q    <= '0;
            idx_q    <= '0;
            drn_q    <= 1'b0;
            dvalid_q <= 1'b0;
            didx_q   <= '0;
            ch_q     <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            min_q    <= min_d;
            max_q    <= max_d;
            idx_q    <= idx_d;
            drn_q    <= drn_d;
            dvalid_q <= state_q == PF_READ;
            didx_q   <= addr_q;
            ch_q     <= ch_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            done_q   <= fin;
        end
    end

    assign rdEn      = state_q == PF_READ;
    assign rdAddr    = addr_q;
    assign busy      = state_q != PF_IDLE;
    assign peakCH    = ch_q;
    assign peakCount = cnt_q;
    assign peakValid = valid_q;
    assign peakDone  = done_q;
endmodule
